// File: rtl/display_pkg.sv
// Shared types and segment constants for the calculator display scanner.
// Segment patterns are active low, bit order gfedcba.
package display_pkg;

    typedef enum logic [0:0] {
        SHOW_ENTRY  = 1'b0,
        SHOW_RESULT = 1'b1
    } mode_e;

    localparam logic [6:0] SEG_BLANK = 7'b111_1111;
    localparam logic [6:0] SEG_E     = 7'b000_0110;
    localparam logic [6:0] SEG_R     = 7'b010_1111;
    localparam logic [3:0] AN_OFF    = 4'b1111;
    localparam logic [5:0] MAX_VAL   = 6'd30;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b100_0000;
            4'd1:    p = 7'b111_1001;
            4'd2:    p = 7'b010_0100;
            4'd3:    p = 7'b011_0000;
            4'd4:    p = 7'b001_1001;
            4'd5:    p = 7'b001_0010;
            4'd6:    p = 7'b000_0010;
            4'd7:    p = 7'b111_1000;
            4'd8:    p = 7'b000_0000;
            4'd9:    p = 7'b001_0000;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/decimal_display.sv
// Combinational 0..30 to two-digit 7-segment decoder (active low).
// Tens digit is blanked below 10; both digits blank for out-of-range values.
module decimal_display
    import display_pkg::*;
(
    input  logic [5:0] value,
    output logic [6:0] segments1,
    output logic [6:0] segments2
);

    logic [3:0] ones;
    logic [3:0] tens;

    assign ones = 4'(value % 6'd10);
    assign tens = 4'(value / 6'd10);

    always_comb begin
        segments1 = SEG_BLANK;
        segments2 = SEG_BLANK;
        if (value <= MAX_VAL) begin
            segments1 = seg_digit(ones);
            if (value >= 6'd10) begin
                segments2 = seg_digit(tens);
            end
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// 4-digit multiplexed display controller: entry/result arbitration with result hold,
// digit scan prescaler and registered anode/segment drive.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// SHOW_ENTRY  | display the live entry_val, top digit shows 'E'
// SHOW_RESULT | display latched result for the hold time, top digit shows 'r'
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int SCAN_DIV    = 100000,
    parameter int HOLD_CYCLES = 200000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] entry_val,
    input  logic       entry_strobe,
    input  logic [5:0] result_val,
    input  logic       result_strobe,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       showing_result
);

    localparam int PRE_W  = $clog2(SCAN_DIV);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(SCAN_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);

    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("display_scan_ctrl: SCAN_DIV must be >= 2");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
        $error("display_scan_ctrl: HOLD_CYCLES must be >= 1");
    end

    logic [PRE_W-1:0]  pre_cnt;
    logic              scan_tick;
    logic [1:0]        digit_idx;
    mode_e             state;
    mode_e             state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic [5:0]        result_lat;
    logic [5:0]        lat_nxt;
    logic [5:0]        disp_val;
    logic [6:0]        seg_ones;
    logic [6:0]        seg_tens;
    logic [3:0]        an_nxt;
    logic [6:0]        seg_nxt;

    assign scan_tick = (pre_cnt == PRE_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt   <= '0;
            digit_idx <= 2'd0;
        end else begin
            pre_cnt <= scan_tick ? '0 : pre_cnt + PRE_W'(1);
            if (scan_tick) begin
                digit_idx <= digit_idx + 2'd1;
            end
        end
    end

    // A result strobe always wins over a keypress, in either state.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        lat_nxt   = result_lat;
        case (state)
            SHOW_ENTRY: begin
                if (result_strobe) begin
                    lat_nxt   = result_val;
                    hold_nxt  = HOLD_MAX;
                    state_nxt = SHOW_RESULT;
                end
            end
            SHOW_RESULT: begin
                if (result_strobe) begin
                    lat_nxt  = result_val;
                    hold_nxt = HOLD_MAX;
                end else if (entry_strobe) begin
                    state_nxt = SHOW_ENTRY;
                end else if (hold_cnt == '0) begin
                    state_nxt = SHOW_ENTRY;
                end else begin
                    hold_nxt = hold_cnt - HOLD_W'(1);
                end
            end
            default: state_nxt = SHOW_ENTRY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= SHOW_ENTRY;
            hold_cnt       <= '0;
            result_lat     <= 6'd0;
            showing_result <= 1'b0;
        end else begin
            state          <= state_nxt;
            hold_cnt       <= hold_nxt;
            result_lat     <= lat_nxt;
            showing_result <= (state_nxt == SHOW_RESULT);
        end
    end

    assign disp_val = (state == SHOW_RESULT) ? result_lat : entry_val;

    decimal_display u_decimal_display (
        .value     (disp_val),
        .segments1 (seg_ones),
        .segments2 (seg_tens)
    );

    always_comb begin
        an_nxt  = AN_OFF;
        seg_nxt = SEG_BLANK;
        case (digit_idx)
            2'd0: begin
                an_nxt  = 4'b1110;
                seg_nxt = seg_ones;
            end
            2'd1: begin
                an_nxt  = 4'b1101;
                seg_nxt = seg_tens;
            end
            2'd2: begin
                an_nxt  = 4'b1011;
                seg_nxt = SEG_BLANK;
            end
            default: begin
                an_nxt  = 4'b0111;
                seg_nxt = (state == SHOW_RESULT) ? SEG_R : SEG_E;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: cycle-level reference model plus directed scenarios
// with hand-computed display patterns.
module tb_display_scan_ctrl;

    localparam int SCAN_DIV    = 4;
    localparam int HOLD_CYCLES = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] entry_val = 6'd25;
    logic       entry_strobe = 1'b0;
    logic [5:0] result_val = 6'd0;
    logic       result_strobe = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       showing_result;

    int checks = 0;
    int failures = 0;

    display_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .HOLD_CYCLES(HOLD_CYCLES)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .entry_val      (entry_val),
        .entry_strobe   (entry_strobe),
        .result_val     (result_val),
        .result_strobe  (result_strobe),
        .an             (an),
        .seg            (seg),
        .dp             (dp),
        .showing_result (showing_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [6:0] digit_pat(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Reference model: edges counted since reset release, result shown for
    // HOLD_CYCLES edges after a result strobe unless a keypress arrives first.
    int         m_edges = 0;
    bit         m_result = 0;
    int         m_left = 0;
    int         m_lat = 0;
    int         m_val;
    int         m_digit;
    logic [3:0] exp_an = 4'b1111;
    logic [6:0] exp_seg = 7'b1111111;
    logic       exp_show = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_edges  = 0;
            m_result = 0;
            m_left   = 0;
            m_lat    = 0;
            exp_an   = 4'b1111;
            exp_seg  = 7'b1111111;
            exp_show = 1'b0;
        end else begin
            m_edges++;
            m_val   = m_result ? m_lat : int'(entry_val);
            m_digit = ((m_edges - 1) / SCAN_DIV) % 4;
            exp_an  = ~(4'b0001 << m_digit);
            case (m_digit)
                0: exp_seg = (m_val > 30) ? 7'b1111111 : digit_pat(m_val % 10);
                1: exp_seg = (m_val > 30 || m_val < 10) ? 7'b1111111 : digit_pat(m_val / 10);
                2: exp_seg = 7'b1111111;
                default: exp_seg = m_result ? 7'b0101111 : 7'b0000110;
            endcase
            if (result_strobe) begin
                m_result = 1;
                m_left   = HOLD_CYCLES;
                m_lat    = int'(result_val);
            end else if (m_result && entry_strobe) begin
                m_result = 0;
            end else if (m_result) begin
                m_left--;
                if (m_left == 0) m_result = 0;
            end
            exp_show = m_result;
        end
    end

    always @(negedge clk) begin
        chk("model_an", {3'b000, an}, {3'b000, exp_an});
        chk("model_seg", seg, exp_seg);
        chk("model_showing", {6'd0, showing_result}, {6'd0, exp_show});
        chk("model_dp", {6'd0, dp}, 7'd1);
    end

    task automatic pulse_result(input logic [5:0] v, input logic with_entry);
        @(negedge clk);
        result_val    = v;
        result_strobe = 1'b1;
        entry_strobe  = with_entry;
        @(negedge clk);
        result_strobe = 1'b0;
        entry_strobe  = 1'b0;
    endtask

    // Counts showing_result over a window starting at the current negedge and
    // records the settled segment pattern of each digit while the result shows.
    int         hold_len;
    logic [6:0] rec_seg [4];
    task automatic measure_hold();
        hold_len = 0;
        for (int k = 0; k < 4; k++) rec_seg[k] = 7'bxxxxxxx;
        for (int i = 0; i < 40; i++) begin
            if (showing_result) begin
                hold_len++;
                if (i >= 1) begin
                    for (int k = 0; k < 4; k++)
                        if (an == ~(4'b0001 << k)) rec_seg[k] = seg;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_an(input logic [3:0] target, output bit ok);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (an == target) ok = 1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL wait_an: an never reached %b (last %b)", target, an);
        end
    endtask

    bit ok;

    initial begin
        repeat (5) @(negedge clk);
        chk("reset_an", {3'b000, an}, 7'b0001111);
        chk("reset_seg", seg, 7'b1111111);
        chk("reset_showing", {6'd0, showing_result}, 7'd0);
        rst_n = 1'b1;

        @(negedge clk);
        chk("first_an", {3'b000, an}, 7'b0001110);
        chk("ones_25", seg, 7'b0010010);
        repeat (4) @(negedge clk);
        chk("an_d1", {3'b000, an}, 7'b0001101);
        chk("tens_25", seg, 7'b0100100);
        repeat (4) @(negedge clk);
        chk("an_d2", {3'b000, an}, 7'b0001011);
        chk("blank_d2", seg, 7'b1111111);
        repeat (4) @(negedge clk);
        chk("an_d3", {3'b000, an}, 7'b0000111);
        chk("glyph_e", seg, 7'b0000110);

        pulse_result(6'd30, 1'b0);
        measure_hold();
        chk("hold_len_30", 7'(hold_len), 7'd20);
        chk("hold_d0_30", rec_seg[0], 7'b1000000);
        chk("hold_d1_30", rec_seg[1], 7'b0110000);
        chk("hold_d3_r", rec_seg[3], 7'b0101111);
        repeat (16) @(negedge clk);

        pulse_result(6'd12, 1'b0);
        repeat (4) @(negedge clk);
        entry_strobe = 1'b1;
        @(negedge clk);
        entry_strobe = 1'b0;
        chk("preempt_drop", {6'd0, showing_result}, 7'd0);
        repeat (16) @(negedge clk);

        pulse_result(6'd9, 1'b0);
        repeat (4) @(negedge clk);
        pulse_result(6'd7, 1'b1);
        measure_hold();
        chk("prio_hold_len", 7'(hold_len), 7'd20);
        chk("prio_d0_7", rec_seg[0], 7'b1111000);
        chk("prio_d1_blank", rec_seg[1], 7'b1111111);
        repeat (8) @(negedge clk);

        entry_val = 6'd45;
        wait_an(4'b1110, ok);
        if (ok) begin
            @(negedge clk);
            chk("range_d0_blank", seg, 7'b1111111);
        end
        wait_an(4'b1101, ok);
        if (ok) begin
            @(negedge clk);
            chk("range_d1_blank", seg, 7'b1111111);
        end
        wait_an(4'b0111, ok);
        if (ok) begin
            @(negedge clk);
            chk("range_d3_e", seg, 7'b0000110);
        end

        entry_val = 6'd3;
        pulse_result(6'd21, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_an", {3'b000, an}, 7'b0001111);
        chk("async_rst_seg", seg, 7'b1111111);
        chk("async_rst_showing", {6'd0, showing_result}, 7'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_an", {3'b000, an}, 7'b0001110);
        chk("post_rst_ones_3", seg, 7'b0110000);
        repeat (20) @(negedge clk);
        chk("post_rst_entry", {6'd0, showing_result}, 7'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
